// File: rtl/adc_spi_reader.sv
// Serial ADC reader: clocks one conversion frame per request and averages
// 2^AVG_LOG2 good samples. A sample whose null bit is 1 is discarded.
module adc_spi_reader #(
   parameter int ADC_BITWIDTH = 8,
   parameter int SCLK_DIV     = 2,
   parameter int LEAD_BITS    = 3,
   parameter int AVG_LOG2     = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    sdo_i,
   output logic                    cs_n_o,
   output logic                    sclk_o,
   output logic [ADC_BITWIDTH-1:0] ADC_value_o,
   output logic                    valid_o,
   output logic                    busy_o,
   output logic                    err_o
);
   localparam int NBITS = LEAD_BITS + ADC_BITWIDTH;
   localparam int ACC_W = ADC_BITWIDTH + AVG_LOG2;
   localparam int DIV_W = $clog2(SCLK_DIV + 1);
   localparam int BIT_W = $clog2(NBITS + 1);
   localparam int CNT_W = AVG_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                   state_reg, state_next;
   logic [DIV_W-1:0]         div_reg, div_next;
   logic [BIT_W-1:0]         bit_reg, bit_next;
   logic                     high_reg, high_next;
   logic                     cs_n_reg, cs_n_next;
   logic                     sclk_reg, sclk_next;
   logic                     busy_reg, busy_next;
   logic                     valid_reg, valid_next;
   logic                     err_reg, err_next;
   logic                     null_reg, null_next;
   logic [ADC_BITWIDTH-1:0]  value_reg, value_next;
   logic [ADC_BITWIDTH-1:0]  shift_reg, shift_next;
   logic [ACC_W-1:0]         acc_reg, acc_next;
   logic [CNT_W-1:0]         count_reg, count_next;
   logic                     div_last;
   logic [ACC_W-1:0]         acc_sum;

   assign div_last = (div_reg == DIV_W'(SCLK_DIV - 1));
   assign acc_sum  = acc_reg + ACC_W'(shift_reg);

   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      bit_next   = bit_reg;
      high_next  = high_reg;
      cs_n_next  = cs_n_reg;
      sclk_next  = sclk_reg;
      busy_next  = busy_reg;
      valid_next = 1'b0;
      err_next   = 1'b0;
      null_next  = null_reg;
      value_next = value_reg;
      shift_next = shift_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = SETUP;
               cs_n_next  = 1'b0;
               busy_next  = 1'b1;
               div_next   = '0;
            end
         end
         SETUP: begin
            if (div_last) begin
               state_next = SHIFT;
               div_next   = '0;
               bit_next   = '0;
               high_next  = 1'b0;
            end else begin
               div_next = div_reg + 1'b1;
            end
         end
         SHIFT: begin
            if (!div_last) begin
               div_next = div_reg + 1'b1;
            end else if (!high_reg) begin
               // sdo_i is captured on the same edge that raises sclk_o
               div_next  = '0;
               high_next = 1'b1;
               sclk_next = 1'b1;
               if (bit_reg == BIT_W'(LEAD_BITS - 1))
                  null_next = sdo_i;
               else if (bit_reg >= BIT_W'(LEAD_BITS))
                  shift_next = ADC_BITWIDTH'({shift_reg, sdo_i});
            end else begin
               div_next  = '0;
               high_next = 1'b0;
               sclk_next = 1'b0;
               if (bit_reg == BIT_W'(NBITS - 1)) begin
                  state_next = HOLD;
                  cs_n_next  = 1'b1;
                  if (null_reg) begin
                     err_next = 1'b1;
                  end else if (count_reg == CNT_W'((2 ** AVG_LOG2) - 1)) begin
                     value_next = ADC_BITWIDTH'(acc_sum >> AVG_LOG2);
                     valid_next = 1'b1;
                     acc_next   = '0;
                     count_next = '0;
                  end else begin
                     acc_next   = acc_sum;
                     count_next = count_reg + 1'b1;
                  end
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end
         end
         HOLD: begin
            // A held start chains the next frame straight out of HOLD so the
            // chip-select gap stays exactly SCLK_DIV cycles.
            if (div_last) begin
               div_next = '0;
               if (start_i) begin
                  state_next = SETUP;
                  cs_n_next  = 1'b0;
               end else begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
               end
            end else begin
               div_next = div_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         div_reg   <= '0;
         bit_reg   <= '0;
         high_reg  <= 1'b0;
         cs_n_reg  <= 1'b1;
         sclk_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         null_reg  <= 1'b0;
         value_reg <= '0;
         shift_reg <= '0;
         acc_reg   <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
         bit_reg   <= bit_next;
         high_reg  <= high_next;
         cs_n_reg  <= cs_n_next;
         sclk_reg  <= sclk_next;
         busy_reg  <= busy_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
         null_reg  <= null_next;
         value_reg <= value_next;
         shift_reg <= shift_next;
         acc_reg   <= acc_next;
         count_reg <= count_next;
      end
   end

   assign cs_n_o      = cs_n_reg;
   assign sclk_o      = sclk_reg;
   assign busy_o      = busy_reg;
   assign valid_o     = valid_reg;
   assign err_o       = err_reg;
   assign ADC_value_o = value_reg;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: a serial ADC model feeds a default-parameter
// instance and an AVG_LOG2=0 instance; a queue model predicts the averages.
module tb_adc_spi_reader;
   localparam int D = 2;
   localparam int N = 11;

   logic       clk_i = 1'b0;
   logic       rst_i, start_i, sdo_i;
   logic       cs_n_o, sclk_o, valid_o, busy_o, err_o;
   logic [7:0] ADC_value_o;
   logic       cs_n0, sclk0, valid0, busy0, err0;
   logic [7:0] value0;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [10:0] cur_frame = '0;
   int         adc_idx = 0;
   logic       adc_prev_sclk = 1'b0;

   int         good_q[$];
   logic [7:0] exp_value  = 8'h00;
   logic [7:0] exp0_value = 8'h00;

   adc_spi_reader dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sdo_i(sdo_i),
      .cs_n_o(cs_n_o), .sclk_o(sclk_o), .ADC_value_o(ADC_value_o),
      .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
   );

   adc_spi_reader #(.AVG_LOG2(0)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sdo_i(sdo_i),
      .cs_n_o(cs_n0), .sclk_o(sclk0), .ADC_value_o(value0),
      .valid_o(valid0), .busy_o(busy0), .err_o(err0)
   );

   always #5 clk_i = ~clk_i;

   // ADC model: presents bit k of the frame until the k-th sclk rise samples it
   always @(negedge clk_i) begin
      if (cs_n_o) adc_idx = 0;
      else if (sclk_o && !adc_prev_sclk) adc_idx++;
      adc_prev_sclk = sclk_o;
      sdo_i = (!cs_n_o && adc_idx < N) ? cur_frame[10-adc_idx] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [7:0] data, input logic bad, input bit keep,
                        input bit started, input bit poke);
      int cnt, rises, last_t, spacing_err, strobes, gap, sum;
      logic prev;
      logic exp_valid;
      cur_frame = {2'($urandom), bad, data};
      if (!started) begin
         start_i = 1'b1;
         @(negedge clk_i);
      end
      check("cs_n low at frame start", cs_n_o, 0);
      check("busy at frame start", busy_o, 1);
      if (!keep) start_i = 1'b0;
      cnt = 1; rises = 0; last_t = 0; spacing_err = 0; strobes = 0;
      prev = sclk_o;
      while (cnt < 500) begin
         @(negedge clk_i);
         if (cs_n_o) break;
         cnt++;
         if (poke && cnt == 20) start_i = 1'b1;
         if (poke && cnt == 22) start_i = 1'b0;
         if (valid_o || err_o) strobes++;
         if (sclk_o !== prev) begin
            if (last_t == 0) begin
               if (cnt != 2*D+1) spacing_err++;
            end else if (cnt - last_t != D) spacing_err++;
            last_t = cnt;
            if (sclk_o) rises++;
         end
         prev = sclk_o;
      end
      check("cs_n low cycles", cnt, D + 2*D*N);
      check("sclk edge spacing errors", spacing_err, 0);
      check("sclk rises per frame", rises, N);
      check("strobes inside frame", strobes, 0);
      check("sclk low in hold", sclk_o, 0);
      // Reference: queue of good samples, plain average once four are collected
      exp_valid = 1'b0;
      if (!bad) begin
         good_q.push_back(int'(data));
         exp0_value = data;
         if (good_q.size() == 4) begin
            sum = 0;
            foreach (good_q[i]) sum += good_q[i];
            exp_value = 8'(sum / 4);
            exp_valid = 1'b1;
            good_q.delete();
         end
      end
      check("err pulse", err_o, bad);
      check("valid pulse", valid_o, exp_valid);
      check("ADC_value", ADC_value_o, exp_value);
      check("noavg err", err0, bad);
      check("noavg valid", valid0, !bad);
      check("noavg value", value0, exp0_value);
      $display("frame data=0x%02h null=%0d -> value=0x%02h valid=%0d err=%0d",
               data, bad, ADC_value_o, valid_o, err_o);
      if (keep) begin
         gap = 1;
         while (gap < 100) begin
            @(negedge clk_i);
            if (!cs_n_o) break;
            gap++;
         end
         check("cs_n gap back-to-back", gap, D);
      end else begin
         repeat (D) @(negedge clk_i);
         check("busy low after hold", busy_o, 0);
         check("strobe cleared", valid_o | err_o, 0);
         if (poke) begin
            repeat (3) @(negedge clk_i);
            check("no frame from mid-shift start", cs_n_o, 1);
         end
      end
   endtask

   initial begin
      int   rises;
      logic prev;
      rst_i = 1'b1; start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("reset cs_n", cs_n_o, 1);
      check("reset sclk", sclk_o, 0);
      check("reset busy", busy_o, 0);
      check("reset valid", valid_o, 0);
      check("reset err", err_o, 0);
      check("reset value", ADC_value_o, 0);

      repeat (4) frame(8'hA5, 1'b0, 0, 0, 0);
      frame(8'h10, 1'b0, 0, 0, 0);
      frame(8'h20, 1'b0, 0, 0, 0);
      frame(8'h30, 1'b0, 0, 0, 0);
      frame(8'h41, 1'b0, 0, 0, 0);
      check("average 10/20/30/41", ADC_value_o, 8'h28);
      frame(8'($urandom), 1'b0, 0, 0, 0);
      frame(8'($urandom), 1'b1, 0, 0, 0);
      repeat (3) frame(8'($urandom), 1'b0, 0, 0, 0);
      repeat (4) frame(8'hFF, 1'b0, 0, 0, 0);
      check("all-ones average", ADC_value_o, 8'hFF);
      for (int i = 0; i < 8; i++)
         frame(8'($urandom), ($urandom_range(0, 4) == 0), 0, 0, 0);

      // Reset in the middle of a frame, with a partial average pending
      frame(8'($urandom), 1'b0, 0, 0, 0);
      cur_frame = {3'b000, 8'($urandom)};
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 200 && rises < 6; i++) begin
         @(negedge clk_i);
         if (sclk_o && !prev) rises++;
         prev = sclk_o;
      end
      check("reached shift bit 5", rises, 6);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      good_q.delete();
      exp_value = 8'h00;
      exp0_value = 8'h00;
      check("midframe reset cs_n", cs_n_o, 1);
      check("midframe reset sclk", sclk_o, 0);
      check("midframe reset value", ADC_value_o, 0);
      check("midframe reset busy", busy_o, 0);
      check("midframe reset noavg value", value0, 0);
      $display("reset asserted mid-frame at shift bit 5");
      repeat (4) @(negedge clk_i);
      check("idle without start", cs_n_o, 1);
      repeat (4) frame(8'($urandom), 1'b0, 0, 0, 0);

      // start held high: chained frames
      frame(8'($urandom), 1'b0, 1, 0, 0);
      for (int i = 0; i < 3; i++) frame(8'($urandom), 1'b0, 1, 1, 0);
      frame(8'($urandom), 1'b0, 0, 1, 0);

      // start pulse during SHIFT has no effect
      frame(8'($urandom), 1'b0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter ADC_BITWIDTH, default 8, conversion result width.
REQ-002 SHALL have parameter SCLK_DIV, default 2, clk_i cycles per sclk_o half-period (>=1).
REQ-003 SHALL have parameter LEAD_BITS, default 3, sclk periods before the MSB; the last one is the ADC null bit (>=1).
REQ-004 SHALL have parameter AVG_LOG2, default 2, log2 of the number of good samples averaged per output (0 = no averaging).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, reset; it is synchronous and active-high.
REQ-007 SHALL have port start_i, input, 1 bit, conversion request, sampled in IDLE only.
REQ-008 SHALL have port sdo_i, input, 1 bit, ADC serial data, MSB first.
REQ-009 SHALL have port cs_n_o, output, 1 bit, ADC chip select, active low.
REQ-010 SHALL have port sclk_o, output, 1 bit, serial clock, idle low.
REQ-011 SHALL have port ADC_value_o, output, ADC_BITWIDTH bits, averaged result, held between updates; feeds the fan controller's ADC input.
REQ-012 SHALL have port valid_o, output, 1 bit, one-cycle pulse when ADC_value_o updates.
REQ-013 SHALL have port busy_o, output, 1 bit, high while a frame is in progress.
REQ-014 SHALL have port err_o, output, 1 bit, one-cycle pulse on a null-bit error.

Function
REQ-015 SHALL implement the states IDLE, SETUP, SHIFT, HOLD; all outputs SHALL be registered.
REQ-016 IDLE with start_i=1 SHALL go to SETUP on the next edge: cs_n_o=0, busy_o=1.
REQ-017 SETUP SHALL last exactly SCLK_DIV cycles with sclk_o=0, then go to SHIFT.
REQ-018 SHIFT SHALL generate LEAD_BITS+ADC_BITWIDTH sclk periods, each low for SCLK_DIV cycles then high for SCLK_DIV cycles.
REQ-019 sdo_i SHALL be sampled on the clk_i edge that drives sclk_o 0->1.
REQ-020 The first LEAD_BITS-1 samples SHALL be ignored.
REQ-021 Sample LEAD_BITS SHALL be the null bit and must be 0.
REQ-022 The remaining ADC_BITWIDTH samples SHALL be shifted in MSB first.
REQ-023 After the last high phase, the block SHALL enter HOLD: sclk_o=0, cs_n_o=1 for exactly SCLK_DIV cycles, then IDLE with busy_o=0.
REQ-024 Frame length SHALL be SCLK_DIV*(2+2*(LEAD_BITS+ADC_BITWIDTH)) cycles, i.e. 48 at defaults.
REQ-025 start_i held high SHALL give back-to-back frames with cs_n_o high exactly SCLK_DIV cycles between frames.
REQ-026 A null bit of 1 SHALL pulse err_o in the first HOLD cycle and discard the sample: no accumulate, count unchanged.
REQ-027 A good sample SHALL be added to an accumulator of width ADC_BITWIDTH+AVG_LOG2 in the first HOLD cycle, and the good-sample count SHALL increment.
REQ-028 When the count reaches 2^AVG_LOG2, in that same cycle: ADC_value_o SHALL take the accumulator including the current sample, shifted right by AVG_LOG2 (truncating); valid_o SHALL pulse; accumulator and count SHALL clear.
REQ-029 The accumulator SHALL never overflow; its width is sufficient for all-ones inputs.
REQ-030 start_i outside IDLE SHALL be ignored; a frame in progress SHALL always complete.

Reset
REQ-031 rst_i=1 at any edge, including mid-frame, SHALL on that edge set: state IDLE, cs_n_o=1, sclk_o=0, busy_o=0, valid_o=0, err_o=0, ADC_value_o=0, accumulator=0, count=0, shift register=0.
REQ-032 rst_i SHALL have priority over start_i; the first frame after release SHALL begin only when start_i=1 in IDLE.

Verification
REQ-033 Defaults, ADC returns lead "zz0" then 0xA5 for 4 frames -> ADC_value_o=0xA5; valid_o pulses once, at the end of frame 4; frames are 48 cycles each.
REQ-034 Samples 0x10, 0x20, 0x30, 0x41 -> sum 161 -> ADC_value_o=0x28.
REQ-035 Frame 2 has null bit=1 -> err_o pulse; valid_o only after the 5th frame; result excludes the bad sample.
REQ-036 0xFF x4 -> ADC_value_o=0xFF, no overflow; with AVG_LOG2=0, every frame pulses valid_o.
REQ-037 rst_i asserted at SHIFT bit 5 -> next cycle cs_n_o=1, sclk_o=0, ADC_value_o=0; the next 4 frames average fresh.
REQ-038 start_i held high -> cs_n_o high gap exactly 2 cycles, SCLK_DIV on every sclk_o edge measured; start_i pulses during SHIFT have no effect.
